pc_unit_ras: RTL and testbench

Parametrised program-counter unit for the fetch stage; generalises the plain PC register.
- Adds stall, execute-stage redirect and a direct call/return path backed by a return-address stack (RAS).
- Adds a one-cycle boot state with a configurable reset vector.
- Feeds the instruction memory address and the PC+INC value to IF/ID.

---
 rtl/pc_pkg.sv | 9 +
 rtl/ras_stack.sv | 38 +++
 rtl/pc_unit_ras.sv | 82 ++++++++
 tb/tb_pc_unit_ras.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared defaults, FSM state and next-PC source encodings for pc_unit_ras
package pc_pkg;
    localparam int          PC_W_DEF      = 32;
    localparam int          INC_DEF       = 4;
    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC_DEF  = 32'h0000_0080;
    typedef enum logic {BOOT, RUN} state_t;
    typedef enum logic [2:0] {SRC_SEQ, SRC_REDIR, SRC_CALL, SRC_RET, SRC_TRAP, SRC_HOLD} src_t;
endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack; a push when full overwrites the oldest entry
module ras_stack #(
    parameter int PC_W      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic            replace_i,
    input  logic [PC_W-1:0] data_i,
    output logic [PC_W-1:0] top_o,
    output logic            empty_o,
    output logic            full_o
);
    localparam int AW = $clog2(RAS_DEPTH);
    logic [PC_W-1:0] mem [RAS_DEPTH];
    logic [AW-1:0]   top;
    logic [AW:0]     cnt;
    assign top_o   = mem[top];
    assign empty_o = cnt == '0;
    assign full_o  = cnt == (AW+1)'(RAS_DEPTH);
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            top <= '0;
            cnt <= '0;
        end else if (push_i) begin
            top <= top + 1'b1;
            cnt <= full_o ? cnt : cnt + 1'b1;
        end else if (pop_i && !empty_o) begin
            top <= top - 1'b1;
            cnt <= cnt - 1'b1;
        end
    // contents need no reset: the count alone decides what is valid
    always_ff @(posedge clk_i)
        if (push_i) mem[top + 1'b1] <= data_i;
        else if (replace_i) mem[top] <= data_i;
endmodule

// File: rtl/pc_unit_ras.sv
// pc_unit_ras: fetch PC with boot cycle, stall, EX redirect and call/return via a RAS.
// Optional PC_ALIGN_CHECK_EN traps misaligned redirect/call targets to TRAP_VEC.
module pc_unit_ras
    import pc_pkg::*;
#(
    parameter int              PC_W      = PC_W_DEF,
    parameter int              INC       = INC_DEF,
    parameter logic [PC_W-1:0] RESET_VEC = PC_W'(RESET_VEC_DEF),
    parameter logic [PC_W-1:0] TRAP_VEC  = PC_W'(TRAP_VEC_DEF),
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            redirect_valid_i,
    input  logic [PC_W-1:0] redirect_pc_i,
    input  logic            call_i,
    input  logic [PC_W-1:0] call_target_i,
    input  logic            ret_i,
    output logic [PC_W-1:0] pc_o,
    output logic [PC_W-1:0] pc_plus_o,
    output logic            pc_valid_o,
    output logic            ras_empty_o,
    output logic            ras_full_o,
    output logic            ret_miss_o,
    output logic            misalign_o
);
    state_t          state;
    src_t            src;
    logic            run, active, redir_bad, call_bad, push, pop, replace, miss_next;
    logic [PC_W-1:0] ras_top, pc_next;
`ifdef PC_ALIGN_CHECK_EN
    assign redir_bad = |redirect_pc_i[1:0];
    assign call_bad  = |call_target_i[1:0];
`else
    assign redir_bad = 1'b0;
    assign call_bad  = 1'b0;
`endif
    assign run       = state == RUN;
    assign active    = run && !redirect_valid_i && !stall_i;
    assign pc_plus_o = pc_o + PC_W'(INC);
    assign src = !run             ? SRC_HOLD :
                 redirect_valid_i ? (redir_bad ? SRC_TRAP : SRC_REDIR) :
                 stall_i          ? SRC_HOLD :
                 call_i           ? (call_bad ? SRC_TRAP : SRC_CALL) :
                 ret_i            ? (ras_empty_o ? SRC_SEQ : SRC_RET) : SRC_SEQ;
    assign pc_next = src == SRC_REDIR ? redirect_pc_i :
                     src == SRC_CALL  ? call_target_i :
                     src == SRC_RET   ? ras_top :
                     src == SRC_TRAP  ? TRAP_VEC :
                     src == SRC_HOLD  ? pc_o : pc_plus_o;
    // call+ret swaps the top entry; with an empty stack it degrades to a plain push
    assign push      = src == SRC_CALL && (!ret_i || ras_empty_o);
    assign replace   = src == SRC_CALL && ret_i && !ras_empty_o;
    assign pop       = src == SRC_RET;
    assign miss_next = active && !call_i && ret_i && ras_empty_o;
    ras_stack #(.PC_W(PC_W), .RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push_i   (push),
        .pop_i    (pop),
        .replace_i(replace),
        .data_i   (pc_plus_o),
        .top_o    (ras_top),
        .empty_o  (ras_empty_o),
        .full_o   (ras_full_o)
    );
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            state      <= BOOT;
            pc_o       <= RESET_VEC;
            pc_valid_o <= 1'b0;
            ret_miss_o <= 1'b0;
            misalign_o <= 1'b0;
        end else begin
            state      <= RUN;
            pc_valid_o <= 1'b1;
            pc_o       <= pc_next;
            ret_miss_o <= miss_next;
            misalign_o <= src == SRC_TRAP;
        end
endmodule

// File: tb/tb_pc_unit_ras.sv
// tb_pc_unit_ras: directed self-checking bench for pc_unit_ras (RESET_VEC 0x100, RAS_DEPTH 4)
module tb_pc_unit_ras;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        stall_i = 1'b0, redirect_valid_i = 1'b0, call_i = 1'b0, ret_i = 1'b0;
    logic [31:0] redirect_pc_i = '0, call_target_i = '0;
    logic [31:0] pc_o, pc_plus_o;
    logic        pc_valid_o, ras_empty_o, ras_full_o, ret_miss_o, misalign_o;
    int          pass = 0, total = 0;

    pc_unit_ras #(.PC_W(32), .INC(4), .RESET_VEC(32'h100), .TRAP_VEC(32'h80), .RAS_DEPTH(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i),
        .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
        .call_i(call_i), .call_target_i(call_target_i), .ret_i(ret_i),
        .pc_o(pc_o), .pc_plus_o(pc_plus_o), .pc_valid_o(pc_valid_o),
        .ras_empty_o(ras_empty_o), .ras_full_o(ras_full_o),
        .ret_miss_o(ret_miss_o), .misalign_o(misalign_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step(input logic rd, input logic [31:0] rpc, input logic st,
                        input logic cl, input logic [31:0] tgt, input logic rt);
        redirect_valid_i = rd; redirect_pc_i = rpc; stall_i = st;
        call_i = cl; call_target_i = tgt; ret_i = rt;
        @(posedge clk_i); #1;
        redirect_valid_i = 0; stall_i = 0; call_i = 0; ret_i = 0;
    endtask

    task automatic test_reset;
        @(posedge clk_i); #1;
        total++; if (pc_o !== 32'h100 || pc_valid_o !== 1'b0) $display("FAIL reset_pc pc=%h v=%b exp 100/0", pc_o, pc_valid_o); else pass++;
        total++; if ({ras_empty_o, ras_full_o, ret_miss_o, misalign_o} !== 4'b1000) $display("FAIL reset_flags got=%b exp=1000", {ras_empty_o, ras_full_o, ret_miss_o, misalign_o}); else pass++;
        rst_i = 0;
        step(0, 0, 0, 0, 0, 0);
        total++; if (pc_o !== 32'h100 || pc_valid_o !== 1'b1) $display("FAIL boot_exit pc=%h v=%b exp 100/1", pc_o, pc_valid_o); else pass++;
        step(0, 0, 0, 0, 0, 0);
        total++; if (pc_o !== 32'h104) $display("FAIL seq1 pc=%h exp=104", pc_o); else pass++;
        step(0, 0, 0, 0, 0, 0);
        total++; if (pc_o !== 32'h108 || pc_valid_o !== 1'b1) $display("FAIL seq2 pc=%h v=%b exp 108/1", pc_o, pc_valid_o); else pass++;
    endtask

    task automatic test_stall;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 1, 32'h900, 0);
            total++; if (pc_o !== 32'h108 || ras_empty_o !== 1'b1) $display("FAIL stall_hold%0d pc=%h e=%b exp 108/1", i, pc_o, ras_empty_o); else pass++;
        end
        step(1, 32'h200, 1, 0, 0, 0);
        total++; if (pc_o !== 32'h200) $display("FAIL stall_redirect pc=%h exp=200", pc_o); else pass++;
    endtask

    task automatic test_call_ret;
        step(1, 32'h10, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h400, 0);
        total++; if (pc_o !== 32'h400 || ras_empty_o !== 1'b0) $display("FAIL call pc=%h e=%b exp 400/0", pc_o, ras_empty_o); else pass++;
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        total++; if (pc_o !== 32'h408) $display("FAIL call_seq pc=%h exp=408", pc_o); else pass++;
        step(0, 0, 0, 0, 0, 1);
        total++; if (pc_o !== 32'h14 || ras_empty_o !== 1'b1) $display("FAIL ret pc=%h e=%b exp 14/1", pc_o, ras_empty_o); else pass++;
    endtask

    task automatic test_overflow;
        logic [31:0] exp_ret [4] = '{32'h2304, 32'h2204, 32'h2104, 32'h2004};
        step(1, 32'h1000, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 0, 1, 32'h2000 + k * 32'h100, 0);
            total++; if (pc_o !== 32'h2000 + k * 32'h100) $display("FAIL ovf_call%0d pc=%h exp=%h", k, pc_o, 32'h2000 + k * 32'h100); else pass++;
        end
        total++; if (ras_full_o !== 1'b1) $display("FAIL ovf_full got=%b exp=1", ras_full_o); else pass++;
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0, 0, 1);
            total++; if (pc_o !== exp_ret[k] || ret_miss_o !== 1'b0) $display("FAIL ovf_ret%0d pc=%h miss=%b exp %h/0", k, pc_o, ret_miss_o, exp_ret[k]); else pass++;
        end
        total++; if (ras_empty_o !== 1'b1 || ras_full_o !== 1'b0) $display("FAIL ovf_drained e=%b f=%b exp 1/0", ras_empty_o, ras_full_o); else pass++;
        step(0, 0, 0, 0, 0, 1);
        total++; if (pc_o !== 32'h2008 || ret_miss_o !== 1'b1) $display("FAIL ret_miss pc=%h miss=%b exp 2008/1", pc_o, ret_miss_o); else pass++;
        step(0, 0, 0, 0, 0, 0);
        total++; if (pc_o !== 32'h200c || ret_miss_o !== 1'b0) $display("FAIL ret_miss_clear pc=%h miss=%b exp 200c/0", pc_o, ret_miss_o); else pass++;
    endtask

    task automatic test_call_ret_same;
        step(1, 32'h10, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h40, 0);
        step(1, 32'h50, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h600, 1);
        total++; if (pc_o !== 32'h600 || ras_empty_o !== 1'b0 || ras_full_o !== 1'b0) $display("FAIL swap pc=%h e=%b f=%b exp 600/0/0", pc_o, ras_empty_o, ras_full_o); else pass++;
        step(0, 0, 0, 0, 0, 1);
        total++; if (pc_o !== 32'h54 || ras_empty_o !== 1'b1) $display("FAIL swap_ret pc=%h e=%b exp 54/1", pc_o, ras_empty_o); else pass++;
        step(0, 0, 0, 1, 32'h700, 1);
        total++; if (pc_o !== 32'h700 || ret_miss_o !== 1'b0 || ras_empty_o !== 1'b0) $display("FAIL swap_empty pc=%h miss=%b e=%b exp 700/0/0", pc_o, ret_miss_o, ras_empty_o); else pass++;
        step(0, 0, 0, 0, 0, 1);
        total++; if (pc_o !== 32'h58 || ras_empty_o !== 1'b1) $display("FAIL swap_empty_ret pc=%h e=%b exp 58/1", pc_o, ras_empty_o); else pass++;
    endtask

    task automatic test_wrap;
        step(1, 32'hffff_fffc, 0, 0, 0, 0);
        total++; if (pc_o !== 32'hffff_fffc || pc_plus_o !== 32'h0) $display("FAIL wrap_plus pc=%h plus=%h exp fffffffc/0", pc_o, pc_plus_o); else pass++;
        step(0, 0, 0, 0, 0, 0);
        total++; if (pc_o !== 32'h0) $display("FAIL wrap pc=%h exp=0", pc_o); else pass++;
    endtask

    task automatic test_misalign;
        logic [31:0] exp_pc;
        logic        exp_mis;
`ifdef PC_ALIGN_CHECK_EN
        exp_pc = 32'h80; exp_mis = 1'b1;
`else
        exp_pc = 32'h202; exp_mis = 1'b0;
`endif
        step(1, 32'h202, 0, 0, 0, 0);
        total++; if (pc_o !== exp_pc || misalign_o !== exp_mis) $display("FAIL misalign pc=%h mis=%b exp %h/%b", pc_o, misalign_o, exp_pc, exp_mis); else pass++;
        step(0, 0, 0, 0, 0, 0);
        total++; if (misalign_o !== 1'b0 || ras_empty_o !== 1'b1) $display("FAIL misalign_clear mis=%b e=%b exp 0/1", misalign_o, ras_empty_o); else pass++;
    endtask

    task automatic test_reset_mid;
        step(0, 0, 0, 1, 32'h300, 0);
        total++; if (ras_empty_o !== 1'b0) $display("FAIL pre_reset e=%b exp=0", ras_empty_o); else pass++;
        @(posedge clk_i); #2;
        rst_i = 1; #1;
        total++; if (pc_o !== 32'h100 || pc_valid_o !== 1'b0 || ras_empty_o !== 1'b1) $display("FAIL async_reset pc=%h v=%b e=%b exp 100/0/1", pc_o, pc_valid_o, ras_empty_o); else pass++;
        @(posedge clk_i); #1;
        rst_i = 0;
        step(0, 0, 0, 0, 0, 0);
        total++; if (pc_o !== 32'h100 || pc_valid_o !== 1'b1) $display("FAIL reboot pc=%h v=%b exp 100/1", pc_o, pc_valid_o); else pass++;
    endtask

    initial begin
        test_reset;
        test_stall;
        test_call_ret;
        test_overflow;
        test_call_ret_same;
        test_wrap;
        test_misalign;
        test_reset_mid;
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
